// File: rtl/perf_cycle_counter.sv
`timescale 1ns/1ps
// perf_cycle_counter
// Multi-channel cycle-measurement unit. Each channel counts clock cycles
// while its (synchronised) activity flag is high, captures the count on the
// flag's falling edge and holds it for readback through a registered port.
//
// Ports:
//   clock       single clock for all logic
//   resetb      asynchronous active-low reset
//   flag_i      per-channel activity flags, asynchronous to clock
//   mode_i      per channel: 0 = per-pulse, 1 = accumulate across pulses
//   clear_i     synchronous per-channel clear of counter/capture/fresh/overflow
//   rd_en_i     read request
//   rd_sel_i    channel to read
//   rd_data_o   captured value of the selected channel (1-cycle latency)
//   rd_valid_o  one-cycle pulse qualifying rd_data_o
//   rd_fresh_o  selected capture updated since its last read
//   done_o      one-cycle pulse per channel when its capture updates
//   overflow_o  sticky per-channel saturation flag
module perf_cycle_counter #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 33,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [N_CH-1:0]   flag_i,
  input  logic [N_CH-1:0]   mode_i,
  input  logic [N_CH-1:0]   clear_i,
  input  logic              rd_en_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_fresh_o,
  output logic [N_CH-1:0]   done_o,
  output logic [N_CH-1:0]   overflow_o
);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  fs;
  logic [N_CH-1:0]  fd_q;
  logic [N_CH-1:0]  fall;

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cap_q [N_CH];
  logic [N_CH-1:0]  fresh_q;
  logic [N_CH-1:0]  ovf_q;
  logic [N_CH-1:0]  done_q;

  logic [CNT_W-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             rd_fresh_q;

  logic [N_CH-1:0]  rd_hit;
  logic [CNT_W-1:0] sel_cap;
  logic             sel_fresh;

  assign fs   = sync_q[SYNC_STAGES-1];
  assign fall = fd_q & ~fs;

  // Flag synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      fd_q <= '0;
    end else begin
      sync_q[0] <= flag_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      fd_q <= fs;
    end
  end

  // Read mux; selects beyond N_CH match no channel and return zeros.
  always_comb begin
    rd_hit    = '0;
    sel_cap   = '0;
    sel_fresh = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        sel_cap   = cap_q[i];
        sel_fresh = fresh_q[i];
        rd_hit[i] = rd_en_i;
      end
    end
  end

  // Per-channel counter, capture and status.
  // Priority: clear > fall (capture) > read-clears-fresh / count.
  // fall implies fs=0, so capture and counting never coincide.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        cap_q[i] <= '0;
      end
      fresh_q <= '0;
      ovf_q   <= '0;
      done_q  <= '0;
    end else begin
      done_q <= fall & ~clear_i;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (clear_i[i]) begin
          cnt_q[i]   <= '0;
          cap_q[i]   <= '0;
          fresh_q[i] <= 1'b0;
          ovf_q[i]   <= 1'b0;
        end else if (fall[i]) begin
          cap_q[i]   <= cnt_q[i];
          fresh_q[i] <= 1'b1;
          if (!mode_i[i]) cnt_q[i] <= '0;
        end else begin
          if (rd_hit[i]) fresh_q[i] <= 1'b0;
          if (fs[i]) begin
            if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            else                ovf_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Registered read port; data and fresh hold between reads.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_fresh_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q  <= sel_cap;
        rd_fresh_q <= sel_fresh;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_fresh_o = rd_fresh_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_perf_cycle_counter.sv
`timescale 1ns/1ps
// Testbench for perf_cycle_counter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model (unbounded high-cycle counts, saturated on capture).
module tb_perf_cycle_counter;
  localparam int N_CH  = 5;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int SEL_W = 3;
  localparam longint unsigned MAXV = (64'd1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              resetb = 1'b0;
  logic [N_CH-1:0]   flag_i = '0;
  logic [N_CH-1:0]   mode_i = '0;
  logic [N_CH-1:0]   clear_i = '0;
  logic              rd_en_i = 1'b0;
  logic [SEL_W-1:0]  rd_sel_i = '0;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_valid_o;
  logic              rd_fresh_o;
  logic [N_CH-1:0]   done_o;
  logic [N_CH-1:0]   overflow_o;

  always #5 clock = ~clock;

  perf_cycle_counter #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .SEL_W(SEL_W)
  ) dut (
    .clock(clock), .resetb(resetb), .flag_i(flag_i), .mode_i(mode_i),
    .clear_i(clear_i), .rd_en_i(rd_en_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_fresh_o(rd_fresh_o),
    .done_o(done_o), .overflow_o(overflow_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[j] = flag sample taken j+1 edges ago; the synchronised flag seen
  // by the counters lags the pin by SYNC edges.
  logic [N_CH-1:0]  hist [SYNC+1];
  longint unsigned  m_high [N_CH];
  logic [CNT_W-1:0] m_cap [N_CH];
  logic [N_CH-1:0]  m_fresh = '0, m_ovf = '0, m_done = '0;
  logic [CNT_W-1:0] m_data = '0;
  logic             m_valid = 1'b0, m_rfresh = 1'b0;

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int j = 0; j <= SYNC; j++) hist[j] = '0;
      for (int c = 0; c < N_CH; c++) begin m_high[c] = 0; m_cap[c] = '0; end
      m_fresh = '0; m_ovf = '0; m_done = '0;
      m_data = '0; m_valid = 1'b0; m_rfresh = 1'b0;
    end else begin
      logic [N_CH-1:0] f_now, f_prev;
      int sel;
      f_now  = hist[SYNC-1];
      f_prev = hist[SYNC];
      sel    = int'(rd_sel_i);
      m_valid = rd_en_i;
      if (rd_en_i) begin
        m_data   = (sel < N_CH) ? m_cap[sel] : '0;
        m_rfresh = (sel < N_CH) ? m_fresh[sel] : 1'b0;
      end
      for (int c = 0; c < N_CH; c++) begin
        bit fell;
        fell = f_prev[c] && !f_now[c];
        m_done[c] = fell && !clear_i[c];
        if (clear_i[c]) begin
          m_high[c] = 0; m_cap[c] = '0; m_fresh[c] = 1'b0; m_ovf[c] = 1'b0;
        end else if (fell) begin
          m_cap[c]   = CNT_W'((m_high[c] > MAXV) ? MAXV : m_high[c]);
          m_fresh[c] = 1'b1;
          if (!mode_i[c]) m_high[c] = 0;
        end else begin
          if (rd_en_i && sel == c) m_fresh[c] = 1'b0;
          if (f_now[c]) begin
            m_high[c]++;
            if (m_high[c] > MAXV) m_ovf[c] = 1'b1;
          end
        end
      end
      for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = flag_i;
    end
  end

  always @(negedge clock) begin
    chk("rd_valid", rd_valid_o, m_valid);
    chk("rd_data", rd_data_o, m_data);
    if (m_valid) chk("rd_fresh", rd_fresh_o, m_rfresh);
    chk("done", done_o, m_done);
    chk("overflow", overflow_o, m_ovf);
  end

  // ---------------- directed helpers (called just after a negedge) -------
  task automatic rd(input int sel, input logic [63:0] ed, input bit ef, input string name);
    rd_sel_i = SEL_W'(sel);
    rd_en_i  = 1'b1;
    @(negedge clock);
    rd_en_i  = 1'b0;
    chk({name, "_valid"}, rd_valid_o, 1);
    chk({name, "_data"}, rd_data_o, ed);
    chk({name, "_fresh"}, rd_fresh_o, ef);
  endtask

  task automatic pulse(input int ch, input int n, output int ovf_at);
    ovf_at = -1;
    flag_i[ch] = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      if (ovf_at < 0 && overflow_o[ch]) ovf_at = i;
    end
    flag_i[ch] = 1'b0;
  endtask

  task automatic wait_done(input int ch, input string name);
    int cnt = 0;
    int at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (done_o[ch]) begin
        cnt++;
        if (at < 0) at = i;
      end
    end
    chk({name, "_done_count"}, cnt, 1);
    chk({name, "_done_latency"}, at, SYNC + 1);
  endtask

  task automatic clear_ch(input int ch);
    clear_i[ch] = 1'b1;
    @(negedge clock);
    clear_i[ch] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int oa;
    int dn;

    // Reset and idle
    repeat (5) begin
      @(negedge clock);
      chk("reset_rd_data", rd_data_o, 0);
      chk("reset_rd_valid", rd_valid_o, 0);
      chk("reset_rd_fresh", rd_fresh_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_overflow", overflow_o, 0);
    end
    resetb = 1'b1;
    dn = 0;
    repeat (20) begin @(negedge clock); if (done_o != '0) dn++; end
    chk("idle_no_done", dn, 0);

    // Per-pulse count on ch0
    pulse(0, 100, oa);
    wait_done(0, "ch0");
    rd(0, 100, 1, "ch0_read1");
    rd(0, 100, 0, "ch0_read2");

    // Accumulate on ch1
    mode_i[1] = 1'b1;
    pulse(1, 10, oa); wait_done(1, "acc10"); rd(1, 10, 1, "acc10");
    pulse(1, 20, oa); wait_done(1, "acc20"); rd(1, 30, 1, "acc30");
    pulse(1, 30, oa); wait_done(1, "acc30"); rd(1, 60, 1, "acc60");
    clear_ch(1);
    pulse(1, 5, oa); wait_done(1, "acc5"); rd(1, 5, 1, "acc_after_clear");

    // Saturation on ch2
    pulse(2, 300, oa);
    chk("sat_ovf_first_cycle", oa, SYNC + 256);
    wait_done(2, "sat");
    rd(2, 255, 1, "sat");
    chk("sat_ovf_sticky", overflow_o[2], 1);
    clear_ch(2);
    chk("sat_ovf_cleared", overflow_o[2], 0);
    rd(2, 0, 0, "sat_after_clear");

    // Read in the same cycle as a fall on ch3
    pulse(3, 7, oa); wait_done(3, "ch3_a"); rd(3, 7, 1, "ch3_a");
    pulse(3, 12, oa);
    repeat (2) @(negedge clock);
    rd(3, 7, 0, "ch3_read_at_fall");
    chk("ch3_done_at_fall", done_o[3], 1);
    rd(3, 12, 1, "ch3_after_fall");

    // Clear coincident with fall on ch4
    pulse(4, 9, oa);
    repeat (2) @(negedge clock);
    clear_i[4] = 1'b1;
    dn = 0;
    @(negedge clock);
    clear_i[4] = 1'b0;
    if (done_o[4]) dn++;
    repeat (5) begin @(negedge clock); if (done_o[4]) dn++; end
    chk("clear_fall_no_done", dn, 0);
    rd(4, 0, 0, "clear_fall");

    // Out-of-range selects
    rd(5, 0, 0, "oor5");
    rd(7, 0, 0, "oor7");

    // Async reset mid-pulse on ch0
    rd(0, 100, 0, "pre_reset");
    flag_i[0] = 1'b1;
    repeat (20) @(negedge clock);
    @(posedge clock);
    #2 resetb = 1'b0;
    #0.5;
    chk("async_rd_data", rd_data_o, 0);
    chk("async_rd_valid", rd_valid_o, 0);
    chk("async_done", done_o, 0);
    chk("async_overflow", overflow_o, 0);
    #0.5 resetb = 1'b1;
    repeat (30) @(negedge clock);
    flag_i[0] = 1'b0;
    wait_done(0, "reset_mid");
    rd(0, 29, 1, "reset_mid");

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 15) == 0) flag_i[c] = ~flag_i[c];
        if ($urandom_range(0, 99) == 0) mode_i[c] = ~mode_i[c];
        clear_i[c] = ($urandom_range(0, 399) == 0);
      end
      rd_en_i  = ($urandom_range(0, 1) == 1);
      rd_sel_i = SEL_W'($urandom_range(0, 7));
    end
    @(negedge clock);
    flag_i = '0; clear_i = '0; rd_en_i = 1'b0;
    repeat (10) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_cycle_counter.md
# perf_cycle_counter

Multi-channel, parametrised cycle-measurement unit for the vector accelerator user project. Each channel counts clock cycles while an external or internal activity flag (e.g. an mprj_io status pin driven by the accelerator) is high, captures the result on the flag's falling edge and holds it for readback. It replaces bench-only single-flag counting with a synthesizable block. It adds:
- per-channel accumulate mode
- saturation with a sticky overflow
- synchronised inputs
- a registered read port

## Interface
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 33, counter and capture width in bits (8..64)
- SYNC_STAGES, 2, flag synchroniser depth (2..3)
- SEL_W, $clog2(N_CH) min 1, derived, read-select width

Ports:
- clock  in  1  single clock for all logic
- resetb  in  1  asynchronous active-low reset
- flag_i  in  N_CH  activity flags, asynchronous to clock
- mode_i  in  N_CH  per channel: 0 = per-pulse (counter cleared at each falling edge), 1 = accumulate (counter kept across pulses)
- clear_i  in  N_CH  synchronous per-channel clear of counter, capture, fresh and overflow
- rd_en_i  in  1  read request
- rd_sel_i  in  SEL_W  channel to read
- rd_data_o  out  CNT_W  captured value of selected channel
- rd_valid_o  out  1  one-cycle pulse qualifying rd_data_o
- rd_fresh_o  out  1  selected capture updated since its last read (valid with rd_valid_o)
- done_o  out  N_CH  one-cycle pulse per channel when its capture updates
- overflow_o  out  N_CH  sticky, per-channel counter saturated

## Operation
- Sync: each flag_i bit passes through SYNC_STAGES flops to give fs. fd is fs delayed one cycle. fall = fd & ~fs.
- Counter (per channel, CNT_W bits):
  - fs=1 and cnt != all-ones: cnt <= cnt+1.
  - fs=1 and cnt == all-ones: cnt holds and overflow sets.
  - Saturated value stays all-ones; no wrap-around.
- Capture on fall: cap <= cnt, fresh <= 1, done_o pulses next cycle.
  - mode 0: cnt <= 0 in the same cycle.
  - mode 1: cnt holds.
  - mode_i is sampled every cycle. A mode change mid-pulse takes effect at the next fall.
- Captured value equals the number of cycles fs was high:
  - mode 0: for the last pulse.
  - mode 1: total since the last clear or reset.
- clear_i has the highest priority. In the same cycle as fs=1 or fall, cnt, cap, fresh and overflow all go to 0 and done_o does not pulse. The synchronizer is not cleared.
- Read:
  - rd_en_i in cycle N gives rd_data_o = cap[sel], rd_fresh_o = fresh[sel] and rd_valid_o = 1 in cycle N+1.
  - fresh[sel] clears at the end of cycle N.
  - If a capture on the same channel also happens in cycle N, the read returns the old cap with its old fresh. The new capture wins and fresh stays 1.
  - rd_sel_i >= N_CH: rd_data_o = 0, rd_fresh_o = 0, rd_valid_o = 1.
  - rd_data_o holds its last value when rd_valid_o = 0.
- Channels are fully independent; simultaneous falls on all channels all capture.

## Timing
- Reset (resetb low, asynchronous assert; release synchronised by the top level) clears everything:
  - synchronizers, fd, cnt, cap, fresh and overflow all go to 0.
  - Outputs: rd_data_o = 0, rd_valid_o = 0, rd_fresh_o = 0, done_o = 0, overflow_o = 0.
- Reset mid-pulse discards the partial count. A flag still high after release is counted from the first fs=1 cycle, with no spurious fall.
- Latency, flag_i rising edge to first increment: SYNC_STAGES cycles.
- Latency, flag_i falling edge to done_o and cap visible: SYNC_STAGES+1 cycles.
- Read latency is 1 cycle. Back-to-back reads are allowed every cycle.
- overflow_o asserts in the cycle after the first saturating attempt.

## Test plan
- Reset/idle: resetb low 5 cycles, then flag_i=0 for 20 cycles.
  - Required: all outputs 0 and no done_o.
- Per-pulse count: ch0 mode 0, flag_i[0] high for exactly 100 clock-aligned cycles, then low.
  - done_o[0] pulses once, SYNC_STAGES+1 cycles after the fall.
  - Read ch0 returns 100 with fresh=1; a second read returns 100 with fresh=0.
- Accumulate: ch1 mode 1, pulses of 10, 20 and 30 cycles.
  - Captures read 10, 30, 60 in turn.
  - clear_i[1] then a 5-cycle pulse gives 5.
- Saturation: CNT_W=8, ch2 flag high 300 cycles.
  - Capture = 255 and overflow_o[2]=1 from cycle 256 of fs high, staying set after the fall.
  - clear_i[2] returns overflow_o[2] to 0.
- Simultaneous events, each checked separately:
  - Read ch3 in the same cycle as its fall: returns the previous cap; the next read returns the new value with fresh=1.
  - clear_i coincident with fall: no done_o and cap=0.
  - rd_sel_i=N_CH: returns 0 with rd_valid_o=1.
- Async reset mid-pulse: resetb low for 1 ns mid-way through a 50-cycle pulse, released while the flag is still high.
  - Outputs go to 0 immediately.
  - The capture equals the cycles fs was high after release, with no extra done_o.
